// File: rtl/input_debouncer.sv
// input_debouncer
// Conditions raw push-button / header inputs for the downstream subsystem.
// Each channel is synchronised to clk and then debounced against the shared
// divided enable strobe (tick_en). A channel produces a clean level plus
// registered one-clk rise/fall pulses. Channels are fully independent, and
// every output comes straight from a flop.

module input_debouncer #(
  parameter int NUM_CH       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  // The counter only has to reach STABLE_TICKS-1, so it never wraps.
  localparam int               CNT_W   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   dout_r;
    logic                   dout_nxt_s;
    logic                   rise_r;
    logic                   fall_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain: shift the raw input in. The last stage is the only one used.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], din[i]};
      end
    end

    // Qualification: count tick_en samples of a differing level, and clear on any agreement.
    always_comb begin
      cnt_nxt_s  = cnt_r;
      dout_nxt_s = dout_r;
      if (sync_s == dout_r) begin
        cnt_nxt_s = CNT_ZERO;
      end else if (tick_en && (cnt_r == CNT_MAX)) begin
        dout_nxt_s = sync_s;
        cnt_nxt_s  = CNT_ZERO;
      end else if (tick_en) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end

    // State and edge-pulse registers. A pulse is high in the same cycle that dout first shows the new level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r  <= CNT_ZERO;
        dout_r <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_nxt_s;
        dout_r <= dout_nxt_s;
        rise_r <= dout_nxt_s & ~dout_r;
        fall_r <= ~dout_nxt_s & dout_r;
      end
    end

    assign dout[i] = dout_r;
    assign rise[i] = rise_r;
    assign fall[i] = fall_r;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
// Self-checking bench for input_debouncer. It uses two instances:
//   u_dut_a : default parameters (2 ch, 2 sync stages, 4 stable ticks)
//   u_dut_b : 1 ch, 3 sync stages, 1 stable tick
// A per-channel reference model pushes the expected outputs into a queue at
// each clock edge. A checker pops that queue 1 time unit after the edge and
// compares the outputs. Directed checks cover the test-plan scenarios.

module tb_input_debouncer;

  typedef struct packed {
    logic [7:0] sh;
    logic [7:0] cnt;
    logic       dout;
  } ch_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_a;
  logic       tick_b;
  logic [1:0] din_a;
  logic [1:0] dout_a;
  logic [1:0] rise_a;
  logic [1:0] fall_a;
  logic [0:0] din_b;
  logic [0:0] dout_b;
  logic [0:0] rise_b;
  logic [0:0] fall_b;

  int checks = 0;
  int errors = 0;
  int rise_a0_cnt = 0;
  int rise_b_cnt  = 0;
  int snap;

  logic [5:0] qa[$];
  logic [2:0] qb[$];

  ch_t ma0, ma1, mb;
  ch_t na0, na1, nb;

  input_debouncer #(.NUM_CH(2), .SYNC_STAGES(2), .STABLE_TICKS(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_a), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a)
  );

  input_debouncer #(.NUM_CH(1), .SYNC_STAGES(3), .STABLE_TICKS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_b), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference step for one channel. The new level must persist for st tick samples.
  function automatic ch_t ch_step(ch_t s, logic d, logic tk, int ss, int st);
    ch_t  n;
    logic sy;
    n    = s;
    sy   = s.sh[ss-1];
    n.sh = {s.sh[6:0], d};
    if (sy == s.dout) begin
      n.cnt = 8'd0;
    end else if (tk) begin
      if (int'(s.cnt) + 1 >= st) begin
        n.dout = sy;
        n.cnt  = 8'd0;
      end else begin
        n.cnt = s.cnt + 8'd1;
      end
    end
    return n;
  endfunction

  // Model next state from current inputs
  always_comb begin
    na0 = ch_step(ma0, din_a[0], tick_a, 2, 4);
    na1 = ch_step(ma1, din_a[1], tick_a, 2, 4);
    nb  = ch_step(mb,  din_b[0], tick_b, 3, 1);
  end

  // Model state update and push of expected post-edge outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma0 <= '0;
      ma1 <= '0;
      mb  <= '0;
      qa.delete();
      qb.delete();
    end else begin
      qa.push_back({na1.dout, na0.dout,
                    na1.dout & ~ma1.dout, na0.dout & ~ma0.dout,
                    ~na1.dout & ma1.dout, ~na0.dout & ma0.dout});
      qb.push_back({nb.dout, nb.dout & ~mb.dout, ~nb.dout & mb.dout});
      ma0 <= na0;
      ma1 <= na1;
      mb  <= nb;
    end
  end

  // Scoreboard compare after each edge and pulse counting
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (qa.size() > 0) check("sb_a", {26'd0, dout_a, rise_a, fall_a}, {26'd0, qa.pop_front()});
      if (qb.size() > 0) check("sb_b", {29'd0, dout_b, rise_b, fall_b}, {29'd0, qb.pop_front()});
      rise_a0_cnt <= rise_a0_cnt + int'(rise_a[0]);
      rise_b_cnt  <= rise_b_cnt + int'(rise_b[0]);
    end
  end

  initial begin
    rst_n  = 1'b1;
    din_a  = 2'b00;
    din_b  = 1'b0;
    tick_a = 1'b1;
    tick_b = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_rise_a", 32'(rise_a), 32'd0);
    check("rst_fall_a", 32'(fall_a), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: tick_en held, din[0] 0->1 before edge 0
    din_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_dout_pre", 32'(dout_a[0]), 32'd0);
    @(negedge clk);
    check("t1_dout", 32'(dout_a[0]), 32'd1);
    check("t1_rise", 32'(rise_a[0]), 32'd1);
    check("t1_fall", 32'(fall_a), 32'd0);
    @(negedge clk);
    check("t1_rise_end", 32'(rise_a[0]), 32'd0);
    check("t1_dout_hold", 32'(dout_a[0]), 32'd1);

    // 2: 3-clk bounces never qualify
    din_a[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("t2_dout_low", 32'(dout_a[0]), 32'd0);
    snap = rise_a0_cnt;
    for (int k = 0; k < 5; k++) begin
      din_a[0] = 1'b1;
      repeat (3) @(negedge clk);
      din_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("t2_dout_bounce", 32'(dout_a[0]), 32'd0);
    end
    repeat (4) @(negedge clk);
    check("t2_no_rise", 32'(rise_a0_cnt - snap), 32'd0);

    // 3: tick every 3rd clk, sync high from edge 2, ticks at edges 2,5,8,11
    din_a[1] = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick_a = (j % 3 == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (j == 10) check("t3_dout_pre", 32'(dout_a[1]), 32'd0);
      if (j == 11) begin
        check("t3_dout", 32'(dout_a[1]), 32'd1);
        check("t3_rise", 32'(rise_a[1]), 32'd1);
      end
    end
    tick_a = 1'b1;

    // 4: both channels fall together
    din_a[0] = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_dout_11", 32'(dout_a), 32'd3);
    din_a = 2'b00;
    repeat (5) @(negedge clk);
    check("t4_dout_pre", 32'(dout_a), 32'd3);
    @(negedge clk);
    check("t4_dout", 32'(dout_a), 32'd0);
    check("t4_fall", 32'(fall_a), 32'd3);
    check("t4_rise", 32'(rise_a), 32'd0);
    @(negedge clk);
    check("t4_fall_end", 32'(fall_a), 32'd0);

    // 5: async reset mid-count
    din_a[1] = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_dout_10", 32'(dout_a), 32'd2);
    din_a[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_dout", 32'(dout_a), 32'd0);
    check("t5_rst_rise", 32'(rise_a), 32'd0);
    check("t5_rst_fall", 32'(fall_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_dout_pre", 32'(dout_a), 32'd0);
    @(negedge clk);
    check("t5_dout", 32'(dout_a), 32'd3);
    check("t5_rise", 32'(rise_a), 32'd3);

    // 6: SYNC_STAGES=3, STABLE_TICKS=1
    din_b = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_dout_pre", 32'(dout_b), 32'd0);
    @(negedge clk);
    check("t6_dout", 32'(dout_b), 32'd1);
    check("t6_rise", 32'(rise_b), 32'd1);
    din_b = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_dout_low", 32'(dout_b), 32'd0);
    snap = rise_b_cnt;
    #1 din_b = 1'b1;
    #2 din_b = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_subclk_filtered", 32'(rise_b_cnt - snap), 32'd0);
    check("t6_subclk_dout", 32'(dout_b), 32'd0);
    snap = rise_b_cnt;
    din_b = 1'b1;
    @(negedge clk);
    din_b = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_clk_glitch_passes", 32'(rise_b_cnt - snap), 32'd1);
    check("t6_dout_end", 32'(dout_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
